uart_loader: RTL and testbench
==============================

# uart_loader

Frame parser sitting directly downstream of `uart_sr`. It consumes the 16-bit words assembled from the UART byte stream and interprets them as a program-load frame: start address, length, data words, checksum. It writes each data word into instruction/data memory through a single write port and holds the CPU in reset while a frame is in flight. It reports completion or error, then re-arms for the next frame.

## Interface
- `ADDR_WIDTH`, 16: memory address width. Addresses are the low `ADDR_WIDTH` bits of the computed value.
- `TIMEOUT_CYCLES`, 1<<20: maximum number of clocks allowed between consecutive words inside a frame.
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, asynchronous and active-low.
- `uart_word_ready`  in  1  from `uart_sr`. A new word is indicated by a low-to-high transition. The level may stay high for any duration.
- `uart_word`  in  `WORD_WIDTH`  assembled word. Valid when `uart_word_ready` is high.
- `mem_wr`  out  1  single-cycle memory write strobe.
- `mem_addr`  out  `ADDR_WIDTH`  write address.
- `mem_data`  out  `WORD_WIDTH`  write data.
- `cpu_hold`  out  1  high while a frame is in progress. CPU is held in reset.
- `done`  out  1  sticky. The last frame completed with a matching checksum.
- `error`  out  1  sticky. The last frame failed, by checksum mismatch or timeout.

## Operation
- Edge detect:
  - `word_q` is a registered copy of `uart_word_ready`.
  - A word event is `uart_word_ready & ~word_q`.
  - Only word events advance the FSM. A held-high level produces exactly one event.
- Frame format, all 16-bit words:
  - First word: start address S.
  - Second word: length N.
  - Next N words: data D0..DN-1.
  - Last word: checksum C, equal to the sum of D0..DN-1 modulo 2^16.
- FSM states:
  - IDLE:
    - On an event, latch S, clear `done`/`error`, assert `cpu_hold`, go to LEN.
  - LEN:
    - On an event, latch N, clear the index and the running sum.
    - Go to DATA if N≠0, else go to CSUM.
  - DATA:
    - On an event, issue a write with `mem_addr`=(S+index) truncated to `ADDR_WIDTH` and `mem_data`=word.
    - Add the word to the 16-bit running sum and increment the index.
    - Go to CSUM when index+1==N.
  - CSUM:
    - On an event, compare the word to the running sum.
    - Equal: set `done`. Unequal: set `error`.
    - Deassert `cpu_hold` and go to IDLE.
- Timeout:
  - In LEN, DATA and CSUM, a counter runs. It resets on every event.
  - When the counter reaches `TIMEOUT_CYCLES`: set `error`, deassert `cpu_hold`, go to IDLE.
  - Memory writes already issued are not undone.
- Address wrap: S+index wraps modulo 2^`ADDR_WIDTH`. No error is raised.
- A new frame from IDLE clears both sticky flags on its first word.

## Timing
- Reset values, forced asynchronously while `rst`=0:
  - FSM in IDLE.
  - `mem_wr`=0, `mem_addr`=0, `mem_data`=0.
  - `cpu_hold`=0, `done`=0, `error`=0.
  - `word_q`=0, counters=0, sum=0.
- All outputs are registered.
- Event cycle: the clock edge at which `uart_word_ready`=1 is sampled with `word_q`=0.
  - State, `cpu_hold`, `done` and `error` update at that edge.
  - In DATA, `mem_wr`=1 with `mem_addr`/`mem_data` valid during the following cycle.
  - `mem_wr` is high for exactly one cycle per data word.
- `mem_addr`/`mem_data` hold their last values when `mem_wr`=0.
- `cpu_hold`:
  - Rises the cycle after the first word's event.
  - Falls the cycle after the checksum event or the timeout, coincident with `done`/`error` rising.
- Timeout fires after exactly `TIMEOUT_CYCLES` clocks without an event. An event on the same edge as the timeout wins: the counter resets and the event is processed.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded.

## Test plan
- Nominal frame 0x0010, 0x0003, 0x1111, 0x2222, 0x3333, 0x6666:
  - Exactly 3 single-cycle `mem_wr` pulses at addr 0x10/0x11/0x12 with the matching data.
  - `done`=1, `error`=0, `cpu_hold` low afterwards.
- Same frame with checksum 0x6667:
  - All 3 writes occur.
  - `error`=1, `done`=0.
- Zero length frame 0x0040, 0x0000, 0x0000:
  - No `mem_wr`.
  - `done`=1.
- Wrap with `ADDR_WIDTH`=4, frame 0x000F, 0x0002, 0xAAAA, 0x5555, 0xFFFF:
  - Writes at addr 0xF then 0x0.
  - `done`=1.
- Timeout with `TIMEOUT_CYCLES`=100: send 0x0000, 0x0005, 0xABCD, then idle.
  - One write.
  - `error`=1 exactly 100 clocks after the 0xABCD event.
  - `cpu_hold`=0.
  - A following valid frame clears `error` and ends with `done`=1.
- Drive `uart_word_ready` high for 50 cycles per word:
  - Exactly one write per word.
- Assert `rst`=0 mid-DATA:
  - All outputs are 0 asynchronously.
  - A fresh frame afterwards loads correctly.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: program-load frame parser fed by uart_sr.
// Frame: start address S, length N, N data words, checksum C (sum of data mod 2^16).
// Each data word is written to memory at S+index; the CPU is held in reset
// while a frame is in flight. Completion or failure is reported on sticky flags.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset
//   uart_word_ready word-available level from uart_sr (rising edge = new word)
//   uart_word       assembled word, valid while uart_word_ready is high
//   mem_wr          single-cycle memory write strobe
//   mem_addr        write address (low ADDR_WIDTH bits of S+index)
//   mem_data        write data
//   cpu_hold        high while a frame is in progress
//   done            sticky: last frame completed with matching checksum
//   error           sticky: last frame failed (checksum mismatch or timeout)
module uart_loader #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned WORD_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_word_ready,
  input  logic [WORD_WIDTH-1:0] uart_word,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    CSUM
  } state_t;

  state_t                state_q, state_d;
  logic                  word_q, word_d;
  logic [WORD_WIDTH-1:0] start_q, start_d;
  logic [WORD_WIDTH-1:0] len_q, len_d;
  logic [WORD_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  word_event;
  logic                  timeout;
  logic [WORD_WIDTH-1:0] idx_next;

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cnt_d      = '0;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    word_d     = uart_word_ready;
    word_event = uart_word_ready & ~word_q;
    idx_next   = idx_q + WORD_WIDTH'(1);

    // An event on the same edge as the expiry wins: the timeout is suppressed.
    timeout = (state_q != IDLE) && !word_event &&
              (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    if (state_q != IDLE && !word_event) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (word_event) begin
          start_d    = uart_word;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          state_d    = LEN;
        end
      end
      LEN: begin
        if (word_event) begin
          len_d   = uart_word;
          idx_d   = '0;
          sum_d   = '0;
          state_d = (uart_word != '0) ? DATA : CSUM;
        end
      end
      DATA: begin
        if (word_event) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = ADDR_WIDTH'(start_q + idx_q);
          mem_data_d = uart_word;
          sum_d      = sum_q + uart_word;
          idx_d      = idx_next;
          if (idx_next == len_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (word_event) begin
          done_d     = (uart_word == sum_q);
          error_d    = (uart_word != sum_q);
          cpu_hold_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      error_d    = 1'b1;
      cpu_hold_d = 1'b0;
      cnt_d      = '0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      start_q    <= start_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: two instances (16-bit and 4-bit address) share
// one stimulus stream; a frame-level model predicts writes and flags.
module tb_uart_loader;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_word_ready = 1'b0;
  logic [15:0] uart_word = '0;

  logic        wr16, hold16, done16, err16;
  logic [15:0] addr16, data16;
  logic        wr4, hold4, done4, err4;
  logic [3:0]  addr4;
  logic [15:0] data4;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO), .WORD_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .uart_word_ready(uart_word_ready), .uart_word(uart_word),
    .mem_wr(wr16), .mem_addr(addr16), .mem_data(data16),
    .cpu_hold(hold16), .done(done16), .error(err16));

  uart_loader #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO), .WORD_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .uart_word_ready(uart_word_ready), .uart_word(uart_word),
    .mem_wr(wr4), .mem_addr(addr4), .mem_data(data4),
    .cpu_hold(hold4), .done(done4), .error(err4));

  int n_checks = 0;
  int n_errors = 0;

  // Model state (frame level: counts words received within a frame)
  int cyc = 0;
  int ev_cyc = 0;
  bit m_prev = 0;
  bit m_in = 0;
  int m_k = 0;
  int m_s = 0;
  int m_n = 0;
  int m_sum = 0;
  int m_last_ev = 0;
  bit exp_hold = 0;
  bit exp_done = 0;
  bit exp_err = 0;
  int exp_a[4096];
  int exp_d[4096];
  int wr_ptr = 0;

  // Compare-side state
  int rd_ptr = 0;
  int last_a = 0;
  int last_d = 0;
  int n_wr = 0;
  int cap_a16[1024];
  int cap_a4[1024];
  int cap_d[1024];

  logic [15:0] frm[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_prev = 0; m_in = 0; m_k = 0;
        exp_hold = 0; exp_done = 0; exp_err = 0;
      end else if (clk) begin
        int  w;
        bit  ev;
        cyc++;
        ev = uart_word_ready && !m_prev;
        m_prev = uart_word_ready;
        w = int'(uart_word);
        if (ev) begin
          m_last_ev = cyc;
          if (!m_in) begin
            m_s = w; m_in = 1; m_k = 1;
            exp_hold = 1; exp_done = 0; exp_err = 0;
          end else if (m_k == 1) begin
            m_n = w; m_sum = 0; m_k = 2;
          end else if (m_k < m_n + 2) begin
            exp_a[wr_ptr % 4096] = (m_s + m_k - 2) & 32'hFFFF;
            exp_d[wr_ptr % 4096] = w;
            wr_ptr++;
            m_sum = (m_sum + w) & 32'hFFFF;
            m_k++;
          end else begin
            exp_done = (w == m_sum);
            exp_err  = (w != m_sum);
            exp_hold = 0;
            m_in = 0;
          end
        end else if (m_in && (cyc - m_last_ev == TO)) begin
          exp_err = 1; exp_hold = 0; m_in = 0;
        end
      end
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_ptr = wr_ptr; last_a = 0; last_d = 0;
      end
      if (rd_ptr != wr_ptr) begin
        last_a = exp_a[rd_ptr % 4096];
        last_d = exp_d[rd_ptr % 4096];
        rd_ptr++;
        check("mem_wr16", 32'(wr16), 1);
        check("mem_wr4", 32'(wr4), 1);
        cap_a16[n_wr % 1024] = int'(addr16);
        cap_a4[n_wr % 1024]  = int'(addr4);
        cap_d[n_wr % 1024]   = int'(data16);
        n_wr++;
      end else begin
        check("mem_wr16", 32'(wr16), 0);
        check("mem_wr4", 32'(wr4), 0);
      end
      check("mem_addr16", 32'(addr16), last_a & 32'hFFFF);
      check("mem_addr4", 32'(addr4), last_a & 32'hF);
      check("mem_data16", 32'(data16), last_d);
      check("mem_data4", 32'(data4), last_d);
      check("cpu_hold16", 32'(hold16), 32'(exp_hold));
      check("cpu_hold4", 32'(hold4), 32'(exp_hold));
      check("done16", 32'(done16), 32'(exp_done));
      check("done4", 32'(done4), 32'(exp_done));
      check("error16", 32'(err16), 32'(exp_err));
      check("error4", 32'(err4), 32'(exp_err));
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int hold);
    @(negedge clk);
    uart_word_ready = 1'b1;
    uart_word = w;
    @(posedge clk);
    #1 ev_cyc = cyc;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    uart_word_ready = 1'b0;
    uart_word = 16'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input int hold);
    foreach (frm[i]) send_word(frm[i], hold);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr"}, 32'({wr16, wr4}), 0);
    check({tag, "_addr"}, 32'({addr16, addr4}), 0);
    check({tag, "_data"}, 32'({data16, data4}), 0);
    check({tag, "_flags"}, 32'({hold16, done16, err16, hold4, done4, err4}), 0);
  endtask

  initial begin
    int start;
    fork
      model_loop();
      cmp_loop();
    join_none

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame
    start = n_wr;
    frm = '{16'h0010, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
    send_frame(1);
    check("nom_count", 32'(n_wr - start), 3);
    check("nom_a0", 32'(cap_a16[start % 1024]), 32'h10);
    check("nom_a1", 32'(cap_a16[(start + 1) % 1024]), 32'h11);
    check("nom_a2", 32'(cap_a16[(start + 2) % 1024]), 32'h12);
    check("nom_d0", 32'(cap_d[start % 1024]), 32'h1111);
    check("nom_d2", 32'(cap_d[(start + 2) % 1024]), 32'h3333);
    check("nom_flags", 32'({done16, err16, hold16}), 32'b100);

    // Bad checksum
    start = n_wr;
    frm = '{16'h0010, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6667};
    send_frame(2);
    check("bad_count", 32'(n_wr - start), 3);
    check("bad_flags", 32'({done16, err16, hold16}), 32'b010);

    // Zero length
    start = n_wr;
    frm = '{16'h0040, 16'h0000, 16'h0000};
    send_frame(1);
    check("zero_count", 32'(n_wr - start), 0);
    check("zero_flags", 32'({done16, err16}), 32'b10);

    // Address wrap (4-bit instance)
    start = n_wr;
    frm = '{16'h000F, 16'h0002, 16'hAAAA, 16'h5555, 16'hFFFF};
    send_frame(1);
    check("wrap_count", 32'(n_wr - start), 2);
    check("wrap_a0", 32'(cap_a4[start % 1024]), 32'hF);
    check("wrap_a1", 32'(cap_a4[(start + 1) % 1024]), 32'h0);
    check("wrap_a16_1", 32'(cap_a16[(start + 1) % 1024]), 32'h10);
    check("wrap_done", 32'({done4, err4}), 32'b10);

    // Timeout
    start = n_wr;
    frm = '{16'h0000, 16'h0005, 16'hABCD};
    foreach (frm[i]) send_word(frm[i], 1);
    while (err16 !== 1'b1 && (cyc - ev_cyc) < 3 * TO) begin
      @(posedge clk);
      #1;
    end
    check("to_error", 32'(err16), 1);
    check("to_latency", 32'(cyc - ev_cyc), TO);
    @(negedge clk);
    check("to_count", 32'(n_wr - start), 1);
    check("to_hold", 32'({hold16, hold4}), 0);
    frm = '{16'h0010, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
    send_frame(1);
    check("after_to_flags", 32'({done16, err16}), 32'b10);

    // Long held ready level
    start = n_wr;
    frm = '{16'h0200, 16'h0002, 16'h1234, 16'h4321, 16'h5555};
    send_frame(50);
    check("long_count", 32'(n_wr - start), 2);
    check("long_done", 32'(done16), 1);

    // Reset mid-DATA
    frm = '{16'h0300, 16'h0005, 16'h0001, 16'h0002};
    foreach (frm[i]) send_word(frm[i], 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = n_wr;
    frm = '{16'h0010, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
    send_frame(1);
    check("rst_count", 32'(n_wr - start), 3);
    check("rst_a2", 32'(cap_a16[(start + 2) % 1024]), 32'h12);
    check("rst_done", 32'({done16, err16}), 32'b10);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int n;
      int s;
      logic [15:0] w;
      logic [15:0] sum;
      s = $urandom_range(0, 65535);
      n = $urandom_range(0, 6);
      frm = '{16'(s), 16'(n)};
      sum = '0;
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        frm.push_back(w);
        sum = sum + w;
      end
      if ($urandom_range(0, 2) == 0) sum = sum ^ 16'(1 << $urandom_range(0, 15));
      frm.push_back(sum);
      send_frame($urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
